// File: rtl/snake_motion_if.sv
// Control and observation bundle between the button/food logic and the snake motion engine.
// The master side drives direction, pause, grow, restart and the read index; the slave returns body state.
interface snake_motion_if #(
    parameter int GRID_W  = 32,
    parameter int GRID_H  = 24,
    parameter int MAX_LEN = 16
);
    localparam int X_W = $clog2(GRID_W);
    localparam int Y_W = $clog2(GRID_H);
    localparam int L_W = $clog2(MAX_LEN + 1);

    logic [1:0]     moveState;
    logic           isPaused;
    logic           grow;
    logic           restart;
    logic [L_W-1:0] rd_idx;
    logic [X_W-1:0] rd_x;
    logic [Y_W-1:0] rd_y;
    logic           rd_valid;
    logic [X_W-1:0] head_x;
    logic [Y_W-1:0] head_y;
    logic [L_W-1:0] length;
    logic           stepPulse;
    logic           gameOver;

    modport master (
        output moveState, isPaused, grow, restart, rd_idx,
        input  rd_x, rd_y, rd_valid, head_x, head_y, length, stepPulse, gameOver
    );

    modport slave (
        input  moveState, isPaused, grow, restart, rd_idx,
        output rd_x, rd_y, rd_valid, head_x, head_y, length, stepPulse, gameOver
    );
endinterface

// File: rtl/snake_motion_engine.sv
// Periodic snake movement on a toroidal grid: body shift register, growth latch,
// self-collision detection and a combinational body read port for the renderer.
module snake_motion_engine #(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int MAX_LEN  = 16,
    parameter int TICK_DIV = 25000000
) (
    input  logic           clk,
    input  logic           rst_n,
    snake_motion_if.slave  bus
);
    localparam int X_W   = $clog2(GRID_W);
    localparam int Y_W   = $clog2(GRID_H);
    localparam int L_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_W = $clog2(TICK_DIV);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic {ST_RUN, ST_OVER} state_t;

    logic [X_W-1:0]   seg_x_reg [MAX_LEN];
    logic [Y_W-1:0]   seg_y_reg [MAX_LEN];
    logic [L_W-1:0]   length_reg;
    logic [1:0]       dir_reg;
    logic [1:0]       dir_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             grow_pend_reg;
    logic             step_pulse_reg;
    state_t           state_reg;
    state_t           state_next;

    logic             cnt_en;
    logic             tick;
    logic             grow_ok;
    logic             collide;
    logic             commit;
    logic             game_over;
    logic [X_W-1:0]   next_x;
    logic [Y_W-1:0]   next_y;
    logic [L_W-1:0]   chk_len;
    logic [MAX_LEN-1:0] hit;

    function automatic logic [X_W-1:0] init_x(input int i);
        return (i < 3) ? X_W'(GRID_W / 2 - i) : '0;
    endfunction

    function automatic logic [Y_W-1:0] init_y(input int i);
        return (i < 3) ? Y_W'(GRID_H / 2) : '0;
    endfunction

    assign cnt_en  = !bus.isPaused && (state_reg == ST_RUN);
    assign tick    = cnt_en && (cnt_reg == CNT_W'(TICK_DIV - 1));
    assign grow_ok = (grow_pend_reg || bus.grow) && (length_reg < L_W'(MAX_LEN));
    // The tail cell vacates on a non-growing step, so it cannot be hit.
    assign chk_len = grow_ok ? length_reg : length_reg - L_W'(1);
    assign collide = |hit;
    assign commit  = tick && !collide;

    // UP/DOWN and LEFT/RIGHT differ only in bit 0, so the reverse is dir ^ 1.
    assign dir_next = (bus.moveState == (dir_reg ^ 2'b01)) ? dir_reg : bus.moveState;

    always_comb begin
        next_x = seg_x_reg[0];
        next_y = seg_y_reg[0];
        case (dir_next)
            DIR_UP:    next_y = (seg_y_reg[0] == '0) ? Y_W'(GRID_H - 1) : seg_y_reg[0] - Y_W'(1);
            DIR_DOWN:  next_y = (seg_y_reg[0] == Y_W'(GRID_H - 1)) ? '0 : seg_y_reg[0] + Y_W'(1);
            DIR_LEFT:  next_x = (seg_x_reg[0] == '0) ? X_W'(GRID_W - 1) : seg_x_reg[0] - X_W'(1);
            default:   next_x = (seg_x_reg[0] == X_W'(GRID_W - 1)) ? '0 : seg_x_reg[0] + X_W'(1);
        endcase
    end

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_hit
            assign hit[gi] = (L_W'(gi) < chk_len) &&
                             (seg_x_reg[gi] == next_x) && (seg_y_reg[gi] == next_y);
        end
    endgenerate

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        if (bus.restart) begin
            state_next = ST_RUN;
        end else if (state_reg == ST_RUN && tick && collide) begin
            state_next = ST_OVER;
        end
    end

    // FSM: outputs
    always_comb begin
        game_over = (state_reg == ST_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            grow_pend_reg <= 1'b0;
        end else if (bus.restart) begin
            cnt_reg       <= '0;
            grow_pend_reg <= 1'b0;
        end else begin
            if (cnt_en) begin
                cnt_reg <= tick ? '0 : cnt_reg + CNT_W'(1);
            end
            if (tick) begin
                grow_pend_reg <= 1'b0;
            end else if (bus.grow) begin
                grow_pend_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_reg        <= DIR_RIGHT;
            length_reg     <= L_W'(3);
            step_pulse_reg <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_reg[i] <= init_x(i);
                seg_y_reg[i] <= init_y(i);
            end
        end else if (bus.restart) begin
            dir_reg        <= DIR_RIGHT;
            length_reg     <= L_W'(3);
            step_pulse_reg <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_reg[i] <= init_x(i);
                seg_y_reg[i] <= init_y(i);
            end
        end else begin
            step_pulse_reg <= commit;
            if (commit) begin
                dir_reg    <= dir_next;
                length_reg <= length_reg + {{(L_W-1){1'b0}}, grow_ok};
                seg_x_reg[0] <= next_x;
                seg_y_reg[0] <= next_y;
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x_reg[i] <= seg_x_reg[i-1];
                    seg_y_reg[i] <= seg_y_reg[i-1];
                end
            end
        end
    end

    always_comb begin
        bus.rd_x = '0;
        bus.rd_y = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (bus.rd_idx == L_W'(i)) begin
                bus.rd_x = seg_x_reg[i];
                bus.rd_y = seg_y_reg[i];
            end
        end
    end

    assign bus.rd_valid  = (bus.rd_idx < length_reg);
    assign bus.head_x    = seg_x_reg[0];
    assign bus.head_y    = seg_y_reg[0];
    assign bus.length    = length_reg;
    assign bus.stepPulse = step_pulse_reg;
    assign bus.gameOver  = game_over;
endmodule

// File: tb/tb_snake_motion_engine.sv
// Randomized and directed stimulus for snake_motion_engine, checked every cycle
// against a queue-based model of the snake body.
module tb_snake_motion_engine;
    localparam int W  = 32;
    localparam int H  = 24;
    localparam int ML = 16;
    localparam int TD = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    snake_motion_if #(.GRID_W(W), .GRID_H(H), .MAX_LEN(ML)) bus ();

    snake_motion_engine #(.GRID_W(W), .GRID_H(H), .MAX_LEN(ML), .TICK_DIV(TD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: body as a queue of cells, head first.
    int bx[$];
    int by[$];
    int m_dir, m_cnt, m_gp, m_go, m_pulse;

    function automatic void model_init();
        bx.delete();
        by.delete();
        for (int i = 0; i < 3; i++) begin
            bx.push_back(W / 2 - i);
            by.push_back(H / 2);
        end
        m_dir = 3; m_cnt = 0; m_gp = 0; m_go = 0; m_pulse = 0;
    endfunction

    function automatic int opposite(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic void model_edge(input int ms, input int pz, input int gr, input int rs);
        int fire, gp_eff, nd, nx, ny, g, n, hitc;
        if (rs != 0) begin
            model_init();
            return;
        end
        m_pulse = 0;
        fire    = (pz == 0 && m_go == 0 && m_cnt == TD - 1);
        if (pz == 0 && m_go == 0) m_cnt = fire ? 0 : m_cnt + 1;
        gp_eff = (m_gp != 0 || gr != 0);
        if (fire == 0) begin
            m_gp = gp_eff;
            return;
        end
        m_gp = 0;
        nd = (ms == opposite(m_dir)) ? m_dir : ms;
        nx = bx[0];
        ny = by[0];
        case (nd)
            0: ny = (ny - 1 + H) % H;
            1: ny = (ny + 1) % H;
            2: nx = (nx - 1 + W) % W;
            default: nx = (nx + 1) % W;
        endcase
        g    = (gp_eff != 0 && bx.size() < ML);
        n    = g ? bx.size() : bx.size() - 1;
        hitc = 0;
        for (int k = 0; k < n; k++) if (bx[k] == nx && by[k] == ny) hitc = 1;
        if (hitc != 0) begin
            m_go = 1;
        end else begin
            bx.push_front(nx);
            by.push_front(ny);
            if (g == 0) begin
                void'(bx.pop_back());
                void'(by.pop_back());
            end
            m_dir   = nd;
            m_pulse = 1;
        end
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        int idx;
        check_val("head_x", 32'(bus.head_x), bx[0]);
        check_val("head_y", 32'(bus.head_y), by[0]);
        check_val("length", 32'(bus.length), bx.size());
        check_val("stepPulse", 32'(bus.stepPulse), m_pulse);
        check_val("gameOver", 32'(bus.gameOver), m_go);
        idx = int'(bus.rd_idx);
        check_val("rd_valid", 32'(bus.rd_valid), (idx < bx.size()) ? 1 : 0);
        if (idx < bx.size()) begin
            check_val("rd_x", 32'(bus.rd_x), bx[idx]);
            check_val("rd_y", 32'(bus.rd_y), by[idx]);
        end else if (idx >= ML) begin
            check_val("rd_x_oor", 32'(bus.rd_x), 0);
            check_val("rd_y_oor", 32'(bus.rd_y), 0);
        end
    endtask

    task automatic cyc();
        bus.rd_idx = 5'($urandom_range(0, 31));
        @(posedge clk);
        model_edge(int'(bus.moveState), int'(bus.isPaused), int'(bus.grow), int'(bus.restart));
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic pulse_grow();
        bus.grow = 1'b1;
        cyc();
        bus.grow = 1'b0;
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        cyc();
        bus.restart = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.moveState = 2'd3;
        bus.isPaused  = 1'b0;
        bus.grow      = 1'b0;
        bus.restart   = 1'b0;
        bus.rd_idx    = '0;
        model_init();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        bus.rd_idx = 5'd2;
        #1;
        compare_all();
        rst_n = 1'b1;

        // Straight run right, grow to the cap while wrapping across x=31.
        run(12);
        for (int s = 0; s < 24; s++) begin
            pulse_grow();
            run(TD - 1);
        end
        // Reverse request is ignored; then climb up across y=0.
        bus.moveState = 2'd2;
        run(16);
        bus.moveState = 2'd0;
        run(30 * TD);

        // Pause with a grow pulse mid-pause, counter parked at 2.
        bus.moveState = 2'd3;
        pulse_restart();
        run(2);
        bus.isPaused = 1'b1;
        run(4);
        pulse_grow();
        run(5);
        bus.isPaused = 1'b0;
        run(8);

        // Length 5, then UP, LEFT, DOWN runs the head into its own body.
        pulse_restart();
        for (int s = 0; s < 2; s++) begin
            pulse_grow();
            run(TD - 1);
        end
        bus.moveState = 2'd0; run(TD);
        bus.moveState = 2'd2; run(TD);
        bus.moveState = 2'd1; run(3 * TD);
        pulse_restart();
        run(TD);

        // Random phase with one asynchronous reset in the middle.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 5) == 0) bus.moveState = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) bus.isPaused = ~bus.isPaused;
            bus.grow    = ($urandom_range(0, 5) == 0);
            bus.restart = (m_go != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 999) == 0);
            if (i == 3000) begin
                rst_n = 1'b0;
                #1;
                model_init();
                compare_all();
                #1;
                rst_n = 1'b1;
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
